proc_host_driver: RTL
=====================

Name: proc_host_driver

Overview:
- Initiator side of the processor's run handshake: clk / init / req / ack.
- On a start command it holds the processor in init for a fixed number of cycles, then pulses req for one cycle.
- It then waits for a rising edge on ack, measures the run length in cycles, and reports done or timeout.
- Sits between the system or testbench controller and the processor top level, and is the only driver of the processor's init and req.

Parameters:
INIT_CYCLES, 4, number of cycles proc_init is held high per run (must be >= 1)
TIMEOUT, 4096, number of WAIT cycles without an ack edge before the run is declared hung (1 <= TIMEOUT < 2^CW)
CW, 16, width of cycle_count

Ports:
clk  input  1  system clock; all state changes on rising edge
init_n  input  1  asynchronous, active-low reset of this block
start  input  1  request one processor run; sampled only in IDLE
abort  input  1  cancel the current run; sampled in any state
proc_ack  input  1  ack from processor; level, asserted when the program finishes
proc_init  output  1  init (reset) to processor, active high
proc_req  output  1  req (start) to processor; one-cycle pulse
busy  output  1  high while a run is in progress
done  output  1  sticky: last run completed with an ack edge
timeout  output  1  sticky: last run hit TIMEOUT
cycle_count  output  CW  WAIT cycles consumed by the last or current run
run_count  output  8  number of successful runs; wraps 255 -> 0

Behaviour:
- All outputs are registered. Reset is asynchronous, active-low (init_n), released synchronously by the internal logic.
- During and after reset:
  - state = IDLE
  - proc_init = 1 (processor is held in init while the host is in reset), then 0 from the first clock edge after release
  - proc_req = 0, busy = 0, done = 0, timeout = 0, cycle_count = 0, run_count = 0
  - ack_q = 0
- ack_q is a one-cycle register of proc_ack, updated every cycle in every state.
- ack_edge = proc_ack & ~ack_q. It is combinational and used only in WAIT.
- FSM states: IDLE, INIT, REQ, WAIT.
- IDLE:
  - Outputs: proc_init = 0, proc_req = 0, busy = 0.
  - If start = 1 and abort = 0, go to INIT. On the same edge: busy = 1, done = 0, timeout = 0, cycle_count = 0, init counter = INIT_CYCLES - 1.
  - If start and abort are both high, abort wins and the start is dropped.
- INIT:
  - proc_init = 1 for exactly INIT_CYCLES consecutive cycles.
  - The counter decrements each cycle. Go to REQ on the cycle the counter reads 0.
- REQ:
  - proc_init = 0 and proc_req = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - proc_req = 0. cycle_count increments by 1 every WAIT cycle, including the cycle in which the ack edge is seen.
  - Concrete rule: if the ack edge occurs in the Kth WAIT cycle, the final cycle_count = K.
  - On ack_edge: go to IDLE; busy = 0, done = 1, run_count += 1.
  - Otherwise, if the incremented count equals TIMEOUT: go to IDLE; busy = 0, timeout = 1, cycle_count = TIMEOUT.
  - If ack_edge and the timeout condition occur in the same cycle, ack wins (done, not timeout).
  - A proc_ack that is already high on entry to WAIT (stale ack) produces no edge. It is ignored until it is seen low and then rises again.
- abort = 1 in INIT, REQ or WAIT:
  - Next state is IDLE; proc_init = 0, proc_req = 0, busy = 0.
  - done and timeout stay 0. cycle_count holds its value. run_count is unchanged.
- start while busy is ignored; there is no queueing.
- done and timeout are mutually exclusive. Both are cleared only when the next start is accepted, or by reset.
- Reset mid-run: immediate return to the reset values above, and proc_init is forced high asynchronously.

Test Plan:
1. Reset, then start pulse; processor model raises ack 20 cycles after req -> proc_init high exactly 4 cycles, then proc_req high exactly 1 cycle, then done = 1, cycle_count = 20, run_count = 1, busy = 0.
2. TIMEOUT = 8 and the processor never acks -> timeout = 1, done = 0, cycle_count = 8, busy drops on the edge following WAIT cycle 8, run_count unchanged.
3. Stale ack: proc_ack held high throughout INIT/REQ, drops in WAIT cycle 3, rises in WAIT cycle 6 -> done = 1, cycle_count = 6.
4. Abort in WAIT cycle 5 -> next cycle IDLE, busy = 0, done = 0, timeout = 0, cycle_count = 5; a later start clears the stale state and runs normally.
5. Simultaneous events:
   - ack edge exactly in WAIT cycle TIMEOUT -> done = 1, timeout = 0.
   - start and abort together in IDLE -> no run starts.
   - start while busy -> ignored.
6. init_n asserted low mid-WAIT -> proc_init = 1 immediately, all outputs at reset values; after release and 256 successful runs, run_count wraps to 0.

Source files
------------

// File: rtl/proc_host_driver.sv
// proc_host_driver: initiator side of the processor run handshake (init / req / ack).
//
// On an accepted start it holds the processor in init for INIT_CYCLES cycles,
// pulses req for one cycle, then waits for a rising edge on proc_ack. It counts
// the WAIT cycles and reports done (ack seen) or timeout (TIMEOUT cycles with no ack).
//
// Ports:
//   clk          system clock, rising edge
//   init_n       asynchronous active-low reset
//   start        request one run (sampled only in IDLE)
//   abort        cancel the current run (sampled in any state)
//   proc_ack     processor ack level
//   proc_init    processor init, active high (held high while this block is in reset)
//   proc_req     processor start request, one-cycle pulse
//   busy         run in progress
//   done         sticky: last run ended on an ack edge
//   timeout      sticky: last run hit TIMEOUT
//   cycle_count  WAIT cycles consumed by the last or current run
//   run_count    successful runs, wraps 255 -> 0
module proc_host_driver #(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned CW          = 16
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          start,
    input  logic          abort,
    input  logic          proc_ack,
    output logic          proc_init,
    output logic          proc_req,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    output logic [7:0]    run_count
);

    localparam int unsigned   IW          = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] InitLoad    = IW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] TimeoutVal  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StReq,
        StWait
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   init_cnt_q;
    logic            ack_q;
    logic            proc_init_q;
    logic            proc_req_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;
    logic [CW-1:0]   cycle_count_q;
    logic [7:0]      run_count_q;

    logic            ack_edge;
    logic [CW-1:0]   cycle_inc;

    // A stale ack (already high when WAIT is entered) produces no edge here.
    assign ack_edge  = proc_ack & ~ack_q;
    assign cycle_inc = cycle_count_q + CW'(1);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q       <= StIdle;
            init_cnt_q    <= '0;
            ack_q         <= 1'b0;
            proc_init_q   <= 1'b1;  // keep the processor in init while we are in reset
            proc_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            run_count_q   <= '0;
        end else begin
            ack_q <= proc_ack;
            if (abort && (state_q != StIdle)) begin
                state_q     <= StIdle;
                proc_init_q <= 1'b0;
                proc_req_q  <= 1'b0;
                busy_q      <= 1'b0;
                // The aborted WAIT cycle still counts, then the count is frozen.
                if (state_q == StWait) begin
                    cycle_count_q <= cycle_inc;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        proc_init_q <= 1'b0;
                        proc_req_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        if (start && !abort) begin
                            state_q       <= StInit;
                            proc_init_q   <= 1'b1;
                            busy_q        <= 1'b1;
                            done_q        <= 1'b0;
                            timeout_q     <= 1'b0;
                            cycle_count_q <= '0;
                            init_cnt_q    <= InitLoad;
                        end
                    end
                    StInit: begin
                        if (init_cnt_q == '0) begin
                            state_q     <= StReq;
                            proc_init_q <= 1'b0;
                            proc_req_q  <= 1'b1;
                        end else begin
                            init_cnt_q  <= init_cnt_q - IW'(1);
                        end
                    end
                    StReq: begin
                        state_q    <= StWait;
                        proc_req_q <= 1'b0;
                    end
                    StWait: begin
                        cycle_count_q <= cycle_inc;
                        // Ack has priority over a timeout in the same cycle.
                        if (ack_edge) begin
                            state_q     <= StIdle;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            run_count_q <= run_count_q + 8'd1;
                        end else if (cycle_inc == TimeoutVal) begin
                            state_q   <= StIdle;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign proc_init   = proc_init_q;
    assign proc_req    = proc_req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign run_count   = run_count_q;

endmodule
